sdram_start_ctrl: RTL and testbench

- Avalon-MM slave that sequences the SDRAM transfer engine's start/done handshake.
- Software writes GO. The block drives a start pulse of fixed width, waits for the engine's done signal, and enforces a programmable timeout.
- It reports status and a completion count, and raises a level interrupt.
- Sits between the Nios data master and the SDRAM transfer engine, in place of a bare single-bit PIO.

---
 rtl/sdram_start_ctrl_pkg.sv | 26 ++
 rtl/sdram_start_ctrl_sync_edge_detect.sv | 23 ++
 rtl/sdram_start_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_sdram_start_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sdram_start_ctrl_pkg.sv
// Shared encodings for the SDRAM start/done sequencer: FSM states, register map, bit positions.
package sdram_start_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd2;
  localparam logic [1:0] ADDR_COUNT   = 2'd3;

  localparam int CTRL_GO     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_ABORTED = 3;
  localparam int STAT_OVERRUN = 4;

endpackage

// File: rtl/sdram_start_ctrl_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, followed by a registered rising-edge pulse.
// A rising input shows up as a one-cycle pulse three clocks later.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  // sync[1:0] is the synchronizer chain, sync[2] holds the previous synchronized level
  logic [2:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[1:0], din};
      pulse <= sync[1] & ~sync[2];
    end
  end

endmodule

// File: rtl/sdram_start_ctrl.sv
// Avalon-MM sequencer for the SDRAM transfer engine: GO launches a fixed-width start pulse,
// then waits for done with an optional timeout; sticky status, completion count, level irq.
module sdram_start_ctrl
  import sdram_start_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_W       = 24,
  parameter int unsigned DEFAULT_TIMEOUT = 1000000,
  parameter int unsigned START_CYCLES    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        start_out,
  input  logic        done_in
);

  state_t               state;
  state_t               state_nxt;
  logic [3:0]           pulse_cnt;
  logic [TIMEOUT_W-1:0] timer;
  logic [TIMEOUT_W-1:0] timeout_reg;
  logic                 timer_en;
  logic                 irq_en;
  logic                 st_done;
  logic                 st_timeout;
  logic                 st_aborted;
  logic                 st_overrun;
  logic [31:0]          op_count;
  logic [31:0]          rd_mux;
  logic                 done_evt;
  logic                 wr;
  logic                 wr_ctrl;
  logic                 wr_status;
  logic                 wr_timeout;
  logic                 go;
  logic                 abort;
  logic                 busy;
  logic                 timer_hit;
  logic                 op_start;
  logic                 set_done;
  logic                 set_timeout;
  logic                 set_aborted;
  logic                 set_overrun;
  logic                 unused_wdata;

  assign unused_wdata = ^writedata;

  sync_edge_detect u_done_sync (
    .clk   (clk),
    .rst   (reset),
    .din   (done_in),
    .pulse (done_evt)
  );

  assign wr         = chipselect & ~write_n;
  assign wr_ctrl    = wr && (address == ADDR_CTRL);
  assign wr_status  = wr && (address == ADDR_STATUS);
  assign wr_timeout = wr && (address == ADDR_TIMEOUT);
  assign go         = wr_ctrl & writedata[CTRL_GO];
  assign abort      = wr_ctrl & writedata[CTRL_ABORT];
  assign busy       = (state != ST_IDLE);
  // Expiry is the cycle the timer would decrement from 1 to 0; a zero load disables it.
  assign timer_hit  = timer_en && (timer == TIMEOUT_W'(1));

  always_comb begin
    state_nxt   = state;
    op_start    = 1'b0;
    set_done    = 1'b0;
    set_timeout = 1'b0;
    set_aborted = 1'b0;
    set_overrun = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) begin
          state_nxt = ST_START;
          op_start  = 1'b1;
        end
      end
      ST_START: begin
        set_overrun = go;
        if (abort) begin
          state_nxt   = ST_IDLE;
          set_aborted = 1'b1;
        end else if (timer_hit) begin
          state_nxt   = ST_IDLE;
          set_timeout = 1'b1;
        end else if (pulse_cnt == 4'd1) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        set_overrun = go;
        if (abort) begin
          state_nxt   = ST_IDLE;
          set_aborted = 1'b1;
        end else if (done_evt) begin
          state_nxt = ST_FINISH;
          set_done  = 1'b1;
        end else if (timer_hit) begin
          state_nxt   = ST_IDLE;
          set_timeout = 1'b1;
        end
      end
      ST_FINISH: begin
        set_overrun = go;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      start_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      start_out <= (state_nxt == ST_START);
    end
  end

  // The timer copies TIMEOUT only at launch, so register writes mid-operation wait for the next GO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_cnt <= '0;
      timer     <= '0;
      timer_en  <= 1'b0;
    end else if (op_start) begin
      pulse_cnt <= 4'(START_CYCLES);
      timer     <= timeout_reg;
      timer_en  <= (timeout_reg != '0);
    end else begin
      if (state == ST_START)
        pulse_cnt <= pulse_cnt - 4'd1;
      if (((state == ST_START) || (state == ST_WAIT)) && timer_en)
        timer <= timer - TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en      <= 1'b0;
      timeout_reg <= TIMEOUT_W'(DEFAULT_TIMEOUT);
      st_done     <= 1'b0;
      st_timeout  <= 1'b0;
      st_aborted  <= 1'b0;
      st_overrun  <= 1'b0;
      op_count    <= '0;
      irq         <= 1'b0;
      readdata    <= '0;
    end else begin
      if (wr_ctrl)
        irq_en <= writedata[CTRL_IRQ_EN];
      if (wr_timeout)
        timeout_reg <= writedata[TIMEOUT_W-1:0];
      // Hardware set beats a same-cycle write-1-to-clear.
      st_done    <= set_done    | (st_done    & ~(wr_status & writedata[STAT_DONE]));
      st_timeout <= set_timeout | (st_timeout & ~(wr_status & writedata[STAT_TIMEOUT]));
      st_aborted <= set_aborted | (st_aborted & ~(wr_status & writedata[STAT_ABORTED]));
      st_overrun <= set_overrun | (st_overrun & ~(wr_status & writedata[STAT_OVERRUN]));
      if (set_done)
        op_count <= op_count + 32'd1;
      irq      <= irq_en & (st_done | st_timeout);
      readdata <= rd_mux;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en;
      ADDR_STATUS: begin
        rd_mux[STAT_BUSY]    = busy;
        rd_mux[STAT_DONE]    = st_done;
        rd_mux[STAT_TIMEOUT] = st_timeout;
        rd_mux[STAT_ABORTED] = st_aborted;
        rd_mux[STAT_OVERRUN] = st_overrun;
      end
      ADDR_TIMEOUT: rd_mux = 32'(timeout_reg);
      ADDR_COUNT:   rd_mux = op_count;
      default:      rd_mux = '0;
    endcase
  end

endmodule

// File: tb/tb_sdram_start_ctrl.sv
// Bench for sdram_start_ctrl: randomized operations scored by an edge-arithmetic outcome model.
`timescale 1ns/1ps
module tb_sdram_start_ctrl;

  localparam int S   = 4;
  localparam int INF = 1 << 30;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic        start_out;
  logic        done_in;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_count;

  sdram_start_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .start_out  (start_out),
    .done_in    (done_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  // Edge numbers count clocks after the GO write edge (edge 0). done_in rises just after
  // edge r; abort / second GO are written on edges a / g2 (negative = not used).
  task automatic run_op(input string tag, input int t_val, input int r, input int a,
                        input int g2, input bit ien, input bit go_ab);
    int de, te, ae, end_e, last, n, w_exp, irq_exp, width, pulses, irq_first;
    bit exp_done, exp_to, exp_ab, exp_ov, prev;
    logic [31:0] rd;

    bus_write(2'd2, t_val);
    bus_read(2'd2, rd);
    check({tag, "_tmo_rb"}, rd, t_val & 32'h00FF_FFFF);

    // done is recognised 4 edges after the raise, and only once the start pulse is over
    de = (r >= 1) ? r + 4 : INF;
    te = (t_val != 0) ? t_val : INF;
    ae = (a >= 0) ? a : INF;
    exp_ab   = (ae < de) && (ae < te);
    exp_done = !exp_ab && (de <= te);
    exp_to   = !exp_ab && !exp_done;
    exp_ov   = (g2 >= 1);
    end_e    = exp_ab ? ae : (exp_done ? de + 1 : te);
    w_exp    = (ae < te) ? ae : te;
    if (w_exp > S) w_exp = S;
    irq_exp  = !ien ? -1 : (exp_done ? de + 1 : (exp_to ? te + 1 : -1));
    last     = (r + 4 > end_e) ? r + 4 : end_e;
    n        = last + 8;

    @(negedge clk);
    address = 2'd0; writedata = {29'd0, go_ab, ien, 1'b1}; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    width = 0; pulses = 0; prev = 1'b0; irq_first = -1;
    for (int i = 1; i <= n; i++) begin
      chipselect = 1'b0; write_n = 1'b1;
      if (start_out) begin
        width++;
        if (!prev) pulses++;
      end
      prev = start_out;
      if (irq && irq_first < 0) irq_first = i - 1;
      if (i == a) begin
        address = 2'd0; writedata = {29'd0, 1'b1, ien, 1'b0}; chipselect = 1'b1; write_n = 1'b0;
      end
      if (i == g2) begin
        address = 2'd0; writedata = {29'd0, 1'b0, ien, 1'b1}; chipselect = 1'b1; write_n = 1'b0;
      end
      if (i == r + 1) done_in = 1'b1;
      @(negedge clk);
    end
    done_in = 1'b0;
    repeat (5) @(negedge clk);

    if (exp_done) m_count = m_count + 32'd1;
    check({tag, "_start_width"}, width, w_exp);
    check({tag, "_start_pulses"}, pulses, 1);
    check({tag, "_irq_rise"}, irq_first, irq_exp);
    bus_read(2'd1, rd);
    check({tag, "_status"}, rd, {27'd0, exp_ov, exp_ab, exp_to, exp_done, 1'b0});
    bus_read(2'd3, rd);
    check({tag, "_count"}, rd, m_count);
    bus_read(2'd0, rd);
    check({tag, "_ctrl_rb"}, rd, {30'd0, ien, 1'b0});
    check({tag, "_irq_level"}, irq, ien & (exp_done | exp_to));
    bus_write(2'd1, 32'h1E);
    @(negedge clk);
    check({tag, "_irq_cleared"}, irq, 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    int r, t, a, g2, de, te, end_e;

    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; done_in = 1'b0; m_count = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", irq, 1'b0);
    check("rst_start_out", start_out, 1'b0);
    bus_read(2'd1, rd); check("rst_status", rd, 32'd0);
    bus_read(2'd2, rd); check("rst_timeout", rd, 32'd1000000);
    bus_read(2'd3, rd); check("rst_count", rd, 32'd0);
    bus_read(2'd0, rd); check("rst_ctrl", rd, 32'd0);

    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2, rd); check("tmo_upper_zero", rd, 32'h00FF_FFFF);

    run_op("basic", 1000000, 14, -1, -1, 1'b1, 1'b0);
    run_op("tmo20", 20, -1, -1, -1, 1'b1, 1'b0);
    run_op("overrun", 0, 8, -1, 6, 1'b0, 1'b0);
    run_op("abort", 0, 5, 2, -1, 1'b1, 1'b1);
    run_op("stale", 15, 0, -1, -1, 1'b0, 1'b0);

    force dut.op_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.op_count;
    m_count = 32'hFFFF_FFFF;
    bus_read(2'd3, rd); check("preload_count", rd, m_count);
    run_op("tie_wrap", 12, 8, -1, -1, 1'b1, 1'b0);

    for (int k = 0; k < 30; k++) begin
      r  = ($urandom_range(4, 0) == 0) ? -1 : int'($urandom_range(24, 0));
      t  = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(40, 5));
      a  = ($urandom_range(2, 0) == 0) ? int'($urandom_range(14, 1)) : -1;
      de = (r >= 1) ? r + 4 : INF;
      te = (t != 0) ? t : INF;
      if (a >= 0 && (a == de || a == te)) a = -1;
      if (t == 0 && r < 1 && a < 0) begin
        t = 30; te = 30;
      end
      end_e = (de <= te) ? de + 1 : te;
      g2 = (a < 0 && $urandom_range(2, 0) == 0) ? int'($urandom_range(end_e - 1, 1)) : -1;
      run_op("rnd", t, r, a, g2, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    bus_write(2'd2, 32'd50);
    bus_write(2'd0, 32'h1);
    check("pre_reset_start", start_out, 1'b1);
    #2 reset = 1'b1;
    #1 check("async_reset_start", start_out, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    m_count = '0;
    bus_read(2'd1, rd); check("post_rst_status", rd, 32'd0);
    bus_read(2'd2, rd); check("post_rst_timeout", rd, 32'd1000000);
    bus_read(2'd3, rd); check("post_rst_count", rd, m_count);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
